// File: rtl/debounce_sync_if.sv
// Level-input conditioning bus: raw level and count tick in, clean level,
// edge pulses and qualify status out.
interface debounce_sync_if;
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din,
        output en,
        input  dout,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  din,
        input  en,
        output dout,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability filter that only accepts a new
// level after it has held for STABLE_CYCLES enabled ticks; emits edge pulses.
module debounce_sync #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter logic        RST_VAL       = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    debounce_sync_if.slave  bus
);

    generate
        if (STABLE_CYCLES < 1 ||
            64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_param
            $error("debounce_sync: STABLE_CYCLES out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {STABLE, QUALIFY} state_t;

    logic             s1;
    logic             s2;
    logic             dout;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;

    logic             dout_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    state_t           state;

    // Filter state is implied by the registers: disagreement means a change is pending.
    assign state = (s2 != dout) ? QUALIFY : STABLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            dout <= RST_VAL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= bus.din;
            s2   <= s1;
            dout <= dout_nxt;
            cnt  <= cnt_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
        end
    end

    always_comb begin
        dout_nxt = dout;
        cnt_nxt  = cnt;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        case (state)
            STABLE: cnt_nxt = '0;
            QUALIFY: begin
                if (bus.en) begin
                    if (cnt == LAST) begin
                        dout_nxt = s2;
                        cnt_nxt  = '0;
                        rise_nxt = s2;
                        fall_nxt = ~s2;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    always_comb begin
        bus.dout = dout;
        bus.rise = rise;
        bus.fall = fall;
        bus.busy = (state == QUALIFY);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed table plus randomized run of debounce_sync, checked against a
// history-based model of the synchronise-then-qualify rules.
module tb_debounce_sync;
    localparam int   CNT_W = 8;
    localparam int   N     = 4;
    localparam logic RV    = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debounce_sync_if bus ();

    debounce_sync #(.CNT_W(CNT_W), .STABLE_CYCLES(N), .RST_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0;
    int total    = 0;

    // Model: hist[0] is the most recent din sample, hist[1] the level the filter sees.
    logic hist[2];
    logic m_dout = RV;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_run  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic r, input logic d, input logic e);
        logic lvl;
        if (r) begin
            hist[0] = RV; hist[1] = RV;
            m_dout = RV; m_run = 0; m_rise = 1'b0; m_fall = 1'b0;
        end else begin
            lvl = hist[1];
            m_rise = 1'b0; m_fall = 1'b0;
            if (lvl == m_dout) m_run = 0;
            else if (e) begin
                if (m_run == N - 1) begin
                    m_dout = lvl; m_run = 0;
                    m_rise = lvl; m_fall = ~lvl;
                end else m_run++;
            end
            hist[1] = hist[0];
            hist[0] = d;
        end
    endtask

    task automatic step(input logic r, input logic d, input logic e);
        rst = r; bus.din = d; bus.en = e;
        @(posedge clk);
        model_edge(r, d, e);
        #1;
        chk("dout", {31'd0, bus.dout}, {31'd0, m_dout});
        chk("rise", {31'd0, bus.rise}, {31'd0, m_rise});
        chk("fall", {31'd0, bus.fall}, {31'd0, m_fall});
        chk("busy", {31'd0, bus.busy}, {31'd0, (hist[1] != m_dout)});
        chk("cnt", {24'd0, dut.cnt}, m_run);
    endtask

    typedef struct {
        logic rst, din, en;
        logic dout, rise, fall, busy;
        int   cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, d, e, xd, xr, xf, xb, input int xc);
        vec_t v;
        v.rst = r; v.din = d; v.en = e;
        v.dout = xd; v.rise = xr; v.fall = xf; v.busy = xb; v.cnt = xc;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses, edge_at, en_seen, rises, busy_lo, cnt_frz, guard;
        logic e, d;
        hist[0] = RV; hist[1] = RV;
        bus.din = 1'b0; bus.en = 1'b1;

        // reset with din high, then qualify rise on edge 6
        repeat (3) add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 0, 1, 2);
        add(0, 1, 1, 0, 0, 0, 1, 3);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0);
        // clean fall
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 1);
        add(0, 0, 1, 1, 0, 0, 1, 2);
        add(0, 0, 1, 1, 0, 0, 1, 3);
        add(0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // 3-edge glitch
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 1, 2);
        add(0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].din, tbl[i].en);
            chk($sformatf("tbl%0d_dout", i), {31'd0, bus.dout}, {31'd0, tbl[i].dout});
            chk($sformatf("tbl%0d_rise", i), {31'd0, bus.rise}, {31'd0, tbl[i].rise});
            chk($sformatf("tbl%0d_fall", i), {31'd0, bus.fall}, {31'd0, tbl[i].fall});
            chk($sformatf("tbl%0d_busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].busy});
            chk($sformatf("tbl%0d_cnt", i), {24'd0, dut.cnt}, tbl[i].cnt);
        end

        // en gating: one tick in four, dout flips on the 4th enabled qualify edge
        en_seen = 0; edge_at = 0;
        for (int i = 0; i < 80 && edge_at == 0; i++) begin
            e = (i % 4 == 3);
            if (bus.busy && e) en_seen++;
            step(0, 1, e);
            if (bus.dout) edge_at = en_seen;
        end
        chk("en_gate_ticks", edge_at, 4);
        busy_lo = 0; cnt_frz = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (i >= 2 && !bus.busy) busy_lo++;
            if (i >= 2 && dut.cnt != 0) cnt_frz++;
        end
        chk("en0_busy_held", busy_lo, 0);
        chk("en0_cnt_frozen", cnt_frz, 0);
        chk("en0_dout_held", {31'd0, bus.dout}, 1);
        step(1, 0, 1);
        step(1, 0, 1);

        // bounce, then a stable high level
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            d = ((i / 2) % 2 == 0);
            step(0, d, 1);
            pulses += int'(bus.rise) + int'(bus.fall);
        end
        chk("bounce_no_pulse", pulses, 0);
        edge_at = 0; rises = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1);
            if (bus.rise) begin rises++; if (edge_at == 0) edge_at = i; end
        end
        chk("bounce_rise_edge", edge_at, 6);
        chk("bounce_rise_count", rises, 1);

        // reset while cnt==2
        step(1, 0, 1);
        guard = 0;
        while (dut.cnt != 2 && guard < 12) begin step(0, 1, 1); guard++; end
        chk("midrst_reached_cnt2", {24'd0, dut.cnt}, 2);
        step(1, 1, 1);
        chk("midrst_dout", {31'd0, bus.dout}, 0);
        chk("midrst_cnt", {24'd0, dut.cnt}, 0);
        chk("midrst_rise", {31'd0, bus.rise}, 0);
        edge_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 1);
            if (bus.rise && edge_at == 0) edge_at = i;
        end
        chk("midrst_requal_edge", edge_at, 6);

        // randomized runs against the model
        d = 1'b0;
        for (int i = 0; i < 2000; ) begin
            int run;
            run = $urandom_range(1, 9);
            d = ~d;
            for (int k = 0; k < run; k++, i++)
                step(($urandom_range(0, 199) == 0), d, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
Conditions a raw asynchronous level input, such as a push-button, switch or external strobe, before it drives the data or clock-enable input of a downstream flip-flop stage.
- Synchronises the input with a two-flop chain.
- Filters bounce by requiring the synchronised level to stay stable for a programmable number of enabled cycles.
- Provides a clean registered level plus single-cycle rise and fall pulses.

Parameters:
- CNT_W, 16, width of the stability counter.
- STABLE_CYCLES, 50000, number of consecutive enabled cycles the new level must hold. Legal range is 1 to 2^CNT_W-1; any other value is a compile-time error.
- RST_VAL, 1'b0, level loaded into the synchroniser flops and dout on reset.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- din, input, 1, raw asynchronous input level.
- en, input, 1, count-enable tick, for example a 1 kHz strobe; tie high to count every clock.
- dout, output, 1, debounced registered level.
- rise, output, 1, one-cycle pulse when dout goes 0->1.
- fall, output, 1, one-cycle pulse when dout goes 1->0.
- busy, output, 1, high while a candidate level change is being qualified.

Behaviour:
- Reset is synchronous and has priority over all other logic. On a rising clk edge with rst=1:
  - s1, s2 and dout load RST_VAL.
  - cnt loads 0.
  - rise and fall load 0.
  - busy therefore reads 0 after the reset edge.
- Synchroniser, every edge: s1 <= din; s2 <= s1. No logic sits between s1 and s2.
- busy = (s2 != dout), decoded combinationally from registers only.
- The filter has two states, decoded from registers:
  - STABLE when s2 == dout.
  - QUALIFY when s2 != dout.
- STABLE state, each edge: cnt <= 0; dout holds; rise <= 0 and fall <= 0.
- QUALIFY state with en=0: cnt holds, dout holds, no pulse.
- QUALIFY state with en=1 and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
- QUALIFY state with en=1 and cnt == STABLE_CYCLES-1:
  - dout <= s2 and cnt <= 0.
  - rise <= s2; fall <= ~s2.
  - The pulse is exactly one clk cycle wide and coincides with the first cycle of the new dout value.
- Glitch rejection:
  - If s2 returns to dout before qualification completes, the block is back in STABLE and cnt clears on the next edge, regardless of en.
  - No pulse and no dout change result.
- Latency with en tied high: number the edges 1, 2, 3, ... starting from the first edge at which din is sampled at its new, stable level.
  - s1 captures on edge 1 and s2 on edge 2.
  - Counting occurs on edges 3 to STABLE_CYCLES+2.
  - dout changes, and the pulse asserts, on edge STABLE_CYCLES+2.
- rise and fall are never high in the same cycle. Neither asserts without a matching dout transition.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- Reset mid-qualification: the count is discarded, dout returns to RST_VAL, and no pulse is emitted on or after the reset edge.
- After reset release, if din differs from RST_VAL, a normal qualification runs and produces the corresponding pulse.

Test Plan:
All scenarios use STABLE_CYCLES=4 and RST_VAL=0; en=1 unless noted.
1. Reset:
   - Stimulus: hold rst=1 for 3 edges with din=1.
   - Required: dout=0, rise=fall=busy=0 throughout.
   - Then release rst with din still 1 (edge 1 = first edge after release). Required: busy=1 from after edge 2; dout=1 and a single rise pulse on edge 6.
2. Clean 0->1 then 1->0:
   - Stimulus: din rises and holds; then, after dout=1, din falls and holds.
   - Required: dout=1 on edge 6 with rise high for exactly one cycle, then dout=0 on edge 6 of the second sequence with a single fall pulse.
   - Required: rise and fall are never high together.
3. Glitch:
   - Stimulus: din=1 for exactly 3 edges, then 0.
   - Required: busy high after edges 2-4 and low after edge 5; cnt reaches 3 at most; cnt=0 after edge 6; dout stays 0; no pulses.
4. en gating:
   - Stimulus: en pulses high one cycle in every 4, din steps 0->1.
   - Required: dout changes on the 4th enabled edge in QUALIFY.
   - Then hold en=0 with din changed. Required: busy stays 1, cnt frozen, dout never changes.
5. Bounce:
   - Stimulus: din toggles every 2 cycles for 20 cycles, then holds 1.
   - Required: no pulses during the toggling; exactly one rise on edge 6 after the final stable level.
6. Reset mid-count:
   - Stimulus: assert rst for 1 edge while cnt=2 with din=1.
   - Required: dout=0, cnt=0, no pulse on that edge.
   - Then requalification. Required: rise on edge 6 after release.
